memsum_engine: RTL and testbench

- Parametrised successor to the fixed 4-entry sum controller: a complete dedicated accumulate engine with controller, register file and ALU in one block.
- Computes the sum over the sequence i = 0, S, 2S, … while i <= L, for a runtime limit L and step S.
- Two accumulate modes: plain sum, or alternating add/subtract.
- Has a start/busy/done handshake, and terminates safely when the index counter wraps.
- Sits under the top-level wrapper that drives switches and LEDs.

---
 rtl/memsum_engine.sv | 179 +++++++++++++++++
 tb/tb_memsum_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memsum_engine.sv
// memsum_engine: step/limit accumulate engine (controller, regfile, ALU).
// Sums i = 0, S, 2S, .. while i <= L, in plain or alternating-sign mode.
module memsum_engine #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iStart,
  input  logic [DW-1:0] iLimit,
  input  logic [DW-1:0] iStep,
  input  logic          iMode,
  output logic          oBusy,
  output logic          oDone,
  output logic [DW-1:0] oResult,
  output logic          oOvf
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] R0 = AW'(0);
  localparam logic [AW-1:0] R1 = AW'(1);
  localparam logic [AW-1:0] R2 = AW'(2);
  localparam logic [AW-1:0] R3 = AW'(3);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT1, S_INIT2, S_INIT3,
    S_CHECK, S_ACC, S_INC, S_OUT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] lim_q, lim_d;
  logic [DW-1:0] step_q, step_d;
  logic          mode_q, mode_d;
  logic          par_q, par_d;
  logic          ovf_q, ovf_d;
  logic          wrap_q, wrap_d;
  logic [DW-1:0] res_q, res_d;
  logic          rovf_q, rovf_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  logic [AW-1:0] ra0, ra1, wa;
  logic          we, sub;
  logic [DW-1:0] rd0, rd1, wd;
  logic [DW:0]   alu_ext;
  logic [DW-1:0] alu_y;
  logic          carry, sovf;

  assign rd0 = regs_q[ra0];
  assign rd1 = regs_q[ra1];

  // Wrapping ALU; bit DW is the carry-out on add.
  always_comb begin
    alu_ext = sub ? ({1'b0, rd0} - {1'b0, rd1})
                  : ({1'b0, rd0} + {1'b0, rd1});
    alu_y   = alu_ext[DW-1:0];
    carry   = alu_ext[DW];
    sovf    = ((rd0[DW-1] ^ rd1[DW-1]) == sub)
            && (alu_y[DW-1] != rd0[DW-1]);
  end

  // Controller: next state, regfile port control, flag updates.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    step_d  = step_q;
    mode_d  = mode_q;
    par_d   = par_q;
    ovf_d   = ovf_q;
    wrap_d  = wrap_q;
    res_d   = res_q;
    rovf_d  = rovf_q;
    ra0     = R0;
    ra1     = R0;
    sub     = 1'b0;
    we      = 1'b0;
    wa      = R0;
    wd      = alu_y;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          lim_d   = iLimit;
          step_d  = iStep;
          mode_d  = iMode;
          state_d = S_INIT1;
        end
      end
      S_INIT1: begin
        we      = 1'b1;
        wa      = R1;
        wd      = (step_q == '0) ? DW'(1) : step_q;
        state_d = S_INIT2;
      end
      S_INIT2: begin
        we      = 1'b1;
        wa      = R2;
        state_d = S_INIT3;
      end
      S_INIT3: begin
        we      = 1'b1;
        wa      = R3;
        ovf_d   = 1'b0;
        par_d   = 1'b0;
        wrap_d  = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        ra0 = R2;
        if (wrap_q || (rd0 > lim_q)) state_d = S_OUT;
        else                         state_d = S_ACC;
      end
      S_ACC: begin
        ra0 = R3;
        ra1 = R2;
        sub = mode_q & par_q;
        we  = 1'b1;
        wa  = R3;
        if (mode_q ? sovf : carry) ovf_d = 1'b1;
        par_d   = ~par_q;
        state_d = S_INC;
      end
      S_INC: begin
        ra0 = R2;
        ra1 = R1;
        we  = 1'b1;
        wa  = R2;
        if (carry) wrap_d = 1'b1;
        state_d = S_CHECK;
      end
      S_OUT: begin
        ra0     = R3;
        res_d   = rd0;
        rovf_d  = ovf_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register file write port.
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  // State, latched operands, flags and regfile storage.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      lim_q   <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
      par_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wrap_q  <= 1'b0;
      res_q   <= '0;
      rovf_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      ovf_q   <= ovf_d;
      wrap_q  <= wrap_d;
      res_q   <= res_d;
      rovf_q  <= rovf_d;
      regs_q  <= regs_d;
    end
  end

  assign oBusy   = (state_q != S_IDLE);
  assign oDone   = (state_q == S_DONE);
  assign oResult = res_q;
  assign oOvf    = rovf_q;

endmodule

// File: tb/tb_memsum_engine.sv
// tb_memsum_engine: directed and randomized checks of memsum_engine
// against a loop-level reference model of the summation.
module tb_memsum_engine;

  localparam int DW  = 8;
  localparam int MOD = 2 ** DW;
  localparam int HI  = MOD / 2 - 1;
  localparam int LO  = -(MOD / 2);

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic [DW-1:0] iLimit;
  logic [DW-1:0] iStep;
  logic          iMode;
  logic          oBusy;
  logic          oDone;
  logic [DW-1:0] oResult;
  logic          oOvf;

  int checks = 0;
  int errors = 0;
  int dbl    = 0;
  bit prev_done = 1'b0;
  logic [DW-1:0] last_res = '0;
  logic          last_ovf = 1'b0;

  memsum_engine #(.DW(DW), .NREG(4)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
    .iLimit(iLimit), .iStep(iStep), .iMode(iMode),
    .oBusy(oBusy), .oDone(oDone),
    .oResult(oResult), .oOvf(oOvf)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    if (oDone && prev_done) dbl++;
    prev_done = oDone;
  end

  function automatic void model(input int l, input int s, input int m,
                                output int res, output bit ovf,
                                output int n);
    int st, i, sum, par, t, ss, si;
    st = (s == 0) ? 1 : s;
    i = 0; sum = 0; par = 0; ovf = 0; n = 0;
    while (i <= l) begin
      n++;
      if (m == 0) begin
        t = sum + i;
        if (t >= MOD) ovf = 1;
      end else begin
        ss = (sum > HI) ? sum - MOD : sum;
        si = (i > HI) ? i - MOD : i;
        t = (par != 0) ? ss - si : ss + si;
        if (t > HI || t < LO) ovf = 1;
      end
      sum = t & (MOD - 1);
      par ^= 1;
      i += st;
      if (i >= MOD) break;
    end
    res = sum;
  endfunction

  task automatic start_run(input int l, input int s, input int m,
                           input bit hold);
    @(negedge iClk);
    iLimit = DW'(l);
    iStep  = DW'(s);
    iMode  = m[0];
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    if (!hold) iStart = 1'b0;
  endtask

  task automatic wait_done(input bit scr, output int n,
                           output bit busy_ok, output bit hold_ok);
    n = 1; busy_ok = 1; hold_ok = 1;
    while (oDone !== 1'b1 && n < 2000) begin
      if (oBusy !== 1'b1) busy_ok = 0;
      if (oResult !== last_res || oOvf !== last_ovf) hold_ok = 0;
      if (scr) begin
        iLimit = DW'($urandom);
        iStep  = DW'($urandom);
        iMode  = 1'($urandom);
      end
      @(posedge iClk);
      #1;
      n++;
    end
  endtask

  task automatic finish_run(input string nm, input int n,
                            input bit busy_ok, input bit hold_ok,
                            input int er, input bit eo, input int en);
    checks++;
    if (n !== en) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", nm, n, en);
    end
    checks++;
    if (!busy_ok || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got dropout expected high k+1..done", nm);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s hold: got early change expected %0h", nm,
               last_res);
    end
    checks++;
    if (oResult !== DW'(er) || oOvf !== eo) begin
      errors++;
      $display("FAIL %s result: got %0h/%0b expected %0h/%0b", nm,
               oResult, oOvf, DW'(er), eo);
    end
    last_res = DW'(er);
    last_ovf = eo;
    @(posedge iClk);
    #1;
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0 || oResult !== last_res) begin
      errors++;
      $display("FAIL %s post: got done=%b busy=%b res=%0h expected 0 0 %0h",
               nm, oDone, oBusy, oResult, last_res);
    end
  endtask

  task automatic run_check(input string nm, input int l, input int s,
                           input int m, input int er, input bit eo,
                           input int en, input bit scr);
    int n;
    bit bo, ho;
    start_run(l, s, m, 1'b0);
    wait_done(scr, n, bo, ho);
    finish_run(nm, n, bo, ho, er, eo, en);
  endtask

  task automatic test_reset();
    iRst = 1'b1; iStart = 1'b0;
    iLimit = '0; iStep = '0; iMode = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    checks++;
    if ({oBusy, oDone, oResult, oOvf} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b res=%0h ovf=%b expected 0",
               oBusy, oDone, oResult, oOvf);
    end
  endtask

  task automatic test_directed();
    run_check("sum_s1",    10, 1, 0, 8'h37, 0, 39,  0);
    run_check("sum_s3",    10, 3, 0, 8'h12, 0, 18,  0);
    run_check("sum_s0",    10, 0, 0, 8'h37, 0, 39,  0);
    run_check("alt_s1",    10, 1, 1, 8'h05, 0, 39,  0);
    run_check("wrap",     255, 1, 0, 8'h80, 1, 774, 0);
    run_check("l0_s5",      0, 5, 0, 8'h00, 0, 9,   0);
  endtask

  task automatic test_random();
    int l, s, m, er, en;
    bit eo;
    for (int k = 0; k < 24; k++) begin
      l = $urandom_range(0, MOD - 1);
      s = (k % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(0, MOD - 1);
      m = $urandom_range(0, 1);
      model(l, s, m, er, eo, en);
      run_check($sformatf("rand%0d", k), l, s, m, er, eo, 3 * en + 6, 1);
    end
  endtask

  task automatic test_start_held();
    int n;
    bit bo, ho;
    start_run(10, 1, 0, 1'b1);
    iLimit = 8'd3;
    wait_done(0, n, bo, ho);
    finish_run("held1", n, bo, ho, 55, 0, 39);
    @(posedge iClk);
    #1;
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL held_restart: got busy=%b expected 1", oBusy);
    end
    iStart = 1'b0;
    iLimit = 8'd200;
    wait_done(0, n, bo, ho);
    finish_run("held2", n, bo, ho, 6, 0, 18);
    checks++;
    if (dbl !== 0) begin
      errors++;
      $display("FAIL done_width: got %0d double pulses expected 0", dbl);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    start_run(10, 1, 0, 1'b0);
    repeat (19) @(posedge iClk);
    #1;
    iRst = 1'b1;
    #1;
    checks++;
    if (oBusy !== 1'b0 || oResult !== '0 || oOvf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b res=%0h ovf=%b expected 0 0 0",
               oBusy, oResult, oOvf);
    end
    @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    last_res = '0;
    last_ovf = 1'b0;
    seen = 0;
    repeat (60) begin
      @(posedge iClk);
      #1;
      if (oDone === 1'b1 || oBusy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_nodone: got %0d active cycles expected 0", seen);
    end
    run_check("after_rst", 10, 1, 0, 8'h37, 0, 39, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
